// File: rtl/inv_transcb.sv
// Inverse skin-tone chroma transform: Cb = mean(Y) + (transcb - mean(K_h)) / width(Y).
// Optional build macro INVCB_ROUND_EN: round half up in FIX instead of truncating.
`ifndef FP_WIDTH
`define FP_WIDTH 20
`endif
`ifndef FP_FRAC
`define FP_FRAC 8
`endif
`ifndef TRANSCB_OUTPUT
`define TRANSCB_OUTPUT 10
`endif
`ifndef K_l
`define K_l 125
`endif
`ifndef K_h
`define K_h 188
`endif
`ifndef MeanCb_K_h_fp
`define MeanCb_K_h_fp (108 << `FP_FRAC)
`endif

module inv_transcb #(
  parameter int FP_W     = `FP_WIDTH,
  parameter int FP_FRAC  = `FP_FRAC,
  parameter int DIV_ITER = FP_W + FP_FRAC
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [`TRANSCB_OUTPUT-1:0] transcb,
  input  logic [7:0]                        Y,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [7:0]                        Cb,
  output logic                              div0
);
  localparam int DW = FP_W + FP_FRAC;
  localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
  localparam int MEAN_KH = `MeanCb_K_h_fp;
  localparam int ONE = 1 << FP_FRAC;
  localparam logic [7:0] KL = 8'(`K_l);
  localparam logic [7:0] KH = 8'(`K_h);
  localparam logic signed [FP_W-1:0] MAXPOS  = {1'b0, {(FP_W-1){1'b1}}};
  localparam logic signed [FP_W-1:0] MOSTNEG = {1'b1, {(FP_W-1){1'b0}}};
`ifdef INVCB_ROUND_EN
  localparam logic signed [FP_W:0] RND = (FP_W+1)'(1 << (FP_FRAC-1));
`else
  localparam logic signed [FP_W:0] RND = '0;
`endif

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, OUT} state_t;
  state_t state;

  logic signed [`TRANSCB_OUTPUT-1:0] tcb_q;
  logic [7:0]             y_q;
  logic signed [FP_W-1:0] mean_q, width_q;
  logic                   neg_q;
  logic [DW-1:0]          dq;
  logic [FP_W-1:0]        rem;
  logic [CW-1:0]          cnt;

  // Mean and width curves: flat between K_l and K_h, linear outside.
  logic signed [FP_W-1:0] mean_lut, width_lut;
  assign mean_lut = (y_q < KL) ? FP_W'(MEAN_KH + (int'(KL) - int'(y_q)) * 24) :
                    (y_q > KH) ? FP_W'(MEAN_KH + (int'(y_q) - int'(KH)) * 40) :
                                 FP_W'(MEAN_KH);
  assign width_lut = (y_q < KL) ? FP_W'(ONE + (int'(KL) - int'(y_q)) * 2) :
                     (y_q > KH) ? FP_W'(ONE + (int'(y_q) - int'(KH)) * 3) :
                                  FP_W'(ONE);

  logic signed [FP_W-1:0] diff, absd;
  assign diff = (FP_W'(tcb_q) <<< FP_FRAC) - FP_W'(MEAN_KH);
  assign absd = !diff[FP_W-1] ? diff : (diff == MOSTNEG) ? MAXPOS : -diff;

  // Restoring step: trial subtract in FP_W+1 bits, sign bit picks restore.
  logic [FP_W:0] shifted, trial;
  assign shifted = {rem, dq[DW-1]};
  assign trial   = shifted - {1'b0, width_q};

  logic signed [FP_W-1:0] qs;
  logic signed [FP_W:0]   qsx, sum;
  assign qs  = (|dq[DW-1:FP_W-1]) ? MAXPOS : $signed({1'b0, dq[FP_W-2:0]});
  assign qsx = (FP_W+1)'(qs);
  assign sum = (neg_q ? -qsx : qsx) + (FP_W+1)'(mean_q) + RND;

  function automatic logic [7:0] sat8(input logic signed [FP_W:0] v);
    if (v[FP_W])                   return 8'd0;
    else if (|v[FP_W-1:FP_FRAC+8]) return 8'hFF;
    else                           return v[FP_FRAC+7:FP_FRAC];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Cb        <= '0;
      div0      <= 1'b0;
      tcb_q     <= '0;
      y_q       <= '0;
      mean_q    <= '0;
      width_q   <= '0;
      neg_q     <= 1'b0;
      dq        <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          tcb_q    <= transcb;
          y_q      <= Y;
          in_ready <= 1'b0;
          state    <= PREP;
        end
        PREP: begin
          mean_q  <= mean_lut;
          width_q <= width_lut;
          neg_q   <= diff[FP_W-1];
          dq      <= {absd, {FP_FRAC{1'b0}}};
          rem     <= '0;
          cnt     <= CW'(DIV_ITER - 1);
          div0    <= 1'b0;
          if (y_q >= KL && y_q <= KH) begin
            Cb        <= tcb_q[7:0];
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (width_lut == '0) begin
            div0      <= 1'b1;
            Cb        <= sat8({mean_lut[FP_W-1], mean_lut});
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          rem <= trial[FP_W] ? shifted[FP_W-1:0] : trial[FP_W-1:0];
          dq  <= {dq[DW-2:0], ~trial[FP_W]};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          Cb        <= sat8(sum);
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_transcb.sv
// Directed bench for inv_transcb: passthrough, round trip, saturation, backpressure, div0, reset abort.
module tb_inv_transcb;
  localparam int DIV_ITER = 28;
  localparam int LAT_DIV  = 3 + DIV_ITER;
  localparam int MEANKH   = 108 * 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [9:0] transcb = '0;
  logic [7:0]        Y = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        Cb;
  logic              div0;

  int nvec = 0;
  int nerr = 0;

  inv_transcb dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .transcb(transcb), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .Cb(Cb), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mean_fp(input int y);
    if (y < 125)      return MEANKH + (125 - y) * 24;
    else if (y > 188) return MEANKH + (y - 188) * 40;
    else              return MEANKH;
  endfunction

  function automatic int width_fp(input int y);
    if (y < 125)      return 256 + (125 - y) * 2;
    else if (y > 188) return 256 + (y - 188) * 3;
    else              return 256;
  endfunction

  // Forward transform, rounded to nearest integer transcb.
  function automatic int fwd(input int cb, input int y);
    longint num = longint'(cb * 256 - mean_fp(y)) * width_fp(y);
    return 108 + int'((num + 32768) >>> 16);
  endfunction

  function automatic int inv_model(input int tcb, input int y, input int w);
    longint d = longint'(tcb) * 256 - MEANKH;
    longint q = ((d < 0 ? -d : d) * 256) / w;
    longint s;
    if (q > 524287) q = 524287;
    s = (d < 0 ? -q : q) + mean_fp(y);
`ifdef INVCB_ROUND_EN
    s = s + 128;
`endif
    if (s < 0) return 0;
    s = s / 256;
    return (s > 255) ? 255 : int'(s);
  endfunction

  // Handshake one sample, then count edges (handshake edge included) until out_valid.
  task automatic send(input int t, input int y, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    transcb = 10'(t); Y = 8'(y); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  int lat, exp_cb, got, orig, tc;
  int ys [4] = '{0, 124, 189, 255};
  int cbs[4] = '{0, 'h40, 'h80, 'hFF};

  initial begin
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_cb", int'(Cb), 0);
    chk("rst_div0", int'(div0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Passthrough inside [K_l, K_h], including both edges.
    send('h5A, 156, lat);
    chk("pt_cb", int'(Cb), 'h5A); chk("pt_div0", int'(div0), 0); chk("pt_lat", lat, 2);
    retire();
    chk("retire_valid", int'(out_valid), 0); chk("retire_ready", int'(in_ready), 1);
    send('h33, 125, lat);
    chk("pt_kl_cb", int'(Cb), 'h33); chk("pt_kl_lat", lat, 2);
    retire();
    send(-1, 188, lat);
    chk("pt_kh_cb", int'(Cb), 'hFF); chk("pt_kh_lat", lat, 2);
    retire();

    // Hand-worked: Y=0, transcb=124 -> 127.8 (0x7F truncated, 0x80 rounded).
    send(124, 0, lat);
`ifdef INVCB_ROUND_EN
    chk("hand_cb", int'(Cb), 128);
`else
    chk("hand_cb", int'(Cb), 127);
`endif
    chk("hand_lat", lat, LAT_DIV);
    retire();

    foreach (ys[i]) foreach (cbs[j]) begin
      orig = cbs[j];
      tc   = fwd(orig, ys[i]);
      send(tc, ys[i], lat);
      got = int'(Cb);
      chk($sformatf("rt_y%0d_cb%0d", ys[i], orig), got, inv_model(tc, ys[i], width_fp(ys[i])));
      chk($sformatf("rt_tol_y%0d_cb%0d", ys[i], orig), int'(got - orig <= 1 && orig - got <= 1), 1);
      chk($sformatf("rt_lat_y%0d", ys[i]), lat, LAT_DIV);
      retire();
    end

    // Saturation at the transcb range extremes.
    send(511, 0, lat);  chk("sat_hi", int'(Cb), 255); chk("sat_hi_div0", int'(div0), 0); retire();
    send(-512, 0, lat); chk("sat_lo", int'(Cb), 0); retire();
    send(511, 255, lat); chk("sat_hi_y255", int'(Cb), 255); retire();

    // Backpressure; also drive a competing sample that must be ignored.
    exp_cb = 127;
`ifdef INVCB_ROUND_EN
    exp_cb = 128;
`endif
    send(124, 0, lat);
    transcb = 10'sd0; Y = 8'd156; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_cb_%0d", k), int'(Cb), exp_cb);
      chk($sformatf("bp_valid_%0d", k), int'(out_valid), 1);
      chk($sformatf("bp_ready_%0d", k), int'(in_ready), 0);
    end
    in_valid = 1'b0;
    retire();
    chk("bp_retire_valid", int'(out_valid), 0); chk("bp_retire_ready", int'(in_ready), 1);

    // Zero width from the LUT: mean integer part of Y=0 is 30648/256 = 119.
    force dut.width_lut = '0;
    send(300, 0, lat);
    chk("z_div0", int'(div0), 1); chk("z_cb", int'(Cb), 119); chk("z_lat", lat, 2);
    retire();
    // Width of one LSB overflows the quotient and must saturate.
    force dut.width_lut = 20'sd1;
    send(511, 0, lat);  chk("qov_hi", int'(Cb), 255); chk("qov_div0", int'(div0), 0); retire();
    send(-512, 0, lat); chk("qov_lo", int'(Cb), 0); retire();
    release dut.width_lut;

    // Reset during DIV aborts the sample.
    transcb = 10'sd124; Y = 8'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstdiv_valid", int'(out_valid), 0); chk("rstdiv_ready", int'(in_ready), 1);
    #4 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rstdiv_idle_valid", int'(out_valid), 0); chk("rstdiv_idle_ready", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
